// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier / dot-product datapath: default widths,
// the accumulator FSM state type and a width-generic sign-extension helper.
package mult_pkg;

    localparam int DEF_PROD_W = 64;
    localparam int DEF_ACC_W  = 72;
    localparam int DEF_LEN_W  = 8;

    // Widest value the sign-extension helper handles; callers truncate to their width.
    localparam int EXT_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_e;

    // Replicates bit from_w-1 of v across bits EXT_W-1..from_w.
    function automatic logic [EXT_W-1:0] sign_extend(input logic [EXT_W-1:0] v,
                                                      input int unsigned    from_w);
        int unsigned sh;
        sh = EXT_W - from_w;
        return $unsigned($signed(v << sh) >>> sh);
    endfunction

endpackage

// File: rtl/acc_adder_ovf.sv
// W-bit two's-complement adder with signed-overflow flag; the sum always wraps.
module acc_adder_ovf #(
    parameter int W = 72
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);

    assign sum_o = a_i + b_i;
    // Overflow only when both operands agree in sign and the result does not.
    assign ovf_o = (a_i[W-1] == b_i[W-1]) && (sum_o[W-1] != a_i[W-1]);

endmodule

// File: rtl/dot_product_accumulator.sv
// Sums a programmed number of signed products from the sequential multiplier and
// hands the dot-product result downstream over a valid/ready handshake.
module dot_product_accumulator
    import mult_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              start,
    input  logic [LEN_W-1:0]  vec_len,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic [ACC_W-1:0]  sum_out,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic              busy,
    output logic [LEN_W-1:0]  count,
    output logic              drop_err,
    output logic              overflow
);

    acc_state_e        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic [ACC_W-1:0]  sum_q, sum_d;
    logic              sum_valid_q, sum_valid_d;
    logic              drop_err_q, drop_err_d;
    logic              ovf_q, ovf_d;

    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  add_sum;
    logic              add_ovf;
    logic [LEN_W-1:0]  count_inc;
    logic              accept_start;

    assign prod_ext  = ACC_W'(sign_extend(EXT_W'(prod_in), PROD_W));
    assign count_inc = count_q + LEN_W'(1);

    acc_adder_ovf #(.W(ACC_W)) u_adder (
        .a_i   (acc_q),
        .b_i   (prod_ext),
        .sum_o (add_sum),
        .ovf_o (add_ovf)
    );

    // A new run is taken from IDLE, or from HOLD in the same cycle the result is handed off.
    assign accept_start = en && start &&
                          ((state_q == IDLE) || ((state_q == HOLD) && sum_ready));

    always_comb begin
        // NOTE: every next-state signal defaults to its current value first, so no
        // branch below can leave one unassigned and infer a latch.
        state_d     = state_q;
        acc_d       = acc_q;
        len_d       = len_q;
        count_d     = count_q;
        sum_d       = sum_q;
        sum_valid_d = sum_valid_q;
        drop_err_d  = drop_err_q;
        ovf_d       = ovf_q;

        if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (prod_valid) drop_err_d = 1'b1;
                end
                ACCUM: begin
                    if (prod_valid) begin
                        acc_d   = add_sum;
                        count_d = count_inc;
                        if (add_ovf) ovf_d = 1'b1;
                        if (count_inc == len_q) begin
                            sum_d       = add_sum;
                            sum_valid_d = 1'b1;
                            state_d     = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (prod_valid) drop_err_d = 1'b1;
                    if (sum_ready) begin
                        sum_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (accept_start) begin
                acc_d   = '0;
                count_d = '0;
                ovf_d   = 1'b0;
                len_d   = vec_len;
                if (vec_len != '0) begin
                    sum_valid_d = 1'b0;
                    state_d     = ACCUM;
                end else begin
                    sum_d       = '0;
                    sum_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the async reset
    // aborts any run in progress without emitting a partial sum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            len_q       <= '0;
            count_q     <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            drop_err_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            len_q       <= len_d;
            count_q     <= count_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
            drop_err_q  <= drop_err_d;
            ovf_q       <= ovf_d;
        end
    end

    assign sum_out   = sum_q;
    assign sum_valid = sum_valid_q;
    assign busy      = (state_q == ACCUM);
    assign count     = count_q;
    assign drop_err  = drop_err_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Randomized and directed bench for dot_product_accumulator; a second instance with a
// 64-bit accumulator shares the stimulus to exercise wrap and overflow behaviour.
module tb_dot_product_accumulator;

    localparam int PW  = 64;
    localparam int AW  = 72;
    localparam int LW  = 8;
    localparam int AWN = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic           en;
    logic           start;
    logic [LW-1:0]  vec_len;
    logic [PW-1:0]  prod_in;
    logic           prod_valid;
    logic           sum_ready;

    logic [AW-1:0]  sum_out;
    logic           sum_valid, busy, drop_err, overflow;
    logic [LW-1:0]  count;

    logic [AWN-1:0] sum_out_n;
    logic           sum_valid_n, busy_n, drop_err_n, overflow_n;
    logic [LW-1:0]  count_n;

    dot_product_accumulator #(.PROD_W(PW), .ACC_W(AW), .LEN_W(LW)) dut (
        .clk(clk), .reset(reset), .en(en), .start(start), .vec_len(vec_len),
        .prod_in(prod_in), .prod_valid(prod_valid), .sum_out(sum_out),
        .sum_valid(sum_valid), .sum_ready(sum_ready), .busy(busy), .count(count),
        .drop_err(drop_err), .overflow(overflow)
    );

    dot_product_accumulator #(.PROD_W(PW), .ACC_W(AWN), .LEN_W(LW)) dut_n (
        .clk(clk), .reset(reset), .en(en), .start(start), .vec_len(vec_len),
        .prod_in(prod_in), .prod_valid(prod_valid), .sum_out(sum_out_n),
        .sum_valid(sum_valid_n), .sum_ready(sum_ready), .busy(busy_n), .count(count_n),
        .drop_err(drop_err_n), .overflow(overflow_n)
    );

    always #5 clk = ~clk;

    int           n_pass  = 0;
    int           n_total = 0;
    logic [63:0]  pq [$];
    bit           exp_drop;
    logic [127:0] exp_sum_w, exp_sum_n;
    bit           exp_ovf_w, exp_ovf_n;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Exact running sum: flags overflow when a true partial sum leaves the w-bit range,
    // then keeps the w-bit wrapped value as the new partial sum.
    task automatic model(input int w, output logic [127:0] s, output bit ovf);
        logic signed [127:0] acc, ex, lim;
        acc = '0;
        ovf = 1'b0;
        lim = 128'sd1 <<< (w - 1);
        foreach (pq[i]) begin
            ex = acc + $signed({{64{pq[i][63]}}, pq[i]});
            if (ex >= lim || ex < -lim) ovf = 1'b1;
            acc = (ex <<< (128 - w)) >>> (128 - w);
        end
        s = acc & ((128'd1 << w) - 128'd1);
    endtask

    task automatic check_reset_state();
        check("rst_sum_out",   128'(sum_out),   128'(0));
        check("rst_sum_valid", 128'(sum_valid), 128'(0));
        check("rst_busy",      128'(busy),      128'(0));
        check("rst_count",     128'(count),     128'(0));
        check("rst_drop_err",  128'(drop_err),  128'(0));
        check("rst_overflow",  128'(overflow),  128'(0));
        check("rst_n_sum_out", 128'(sum_out_n), 128'(0));
        check("rst_n_valid",   128'(sum_valid_n), 128'(0));
    endtask

    task automatic launch(input int len);
        start   = 1'b1;
        vec_len = LW'(len);
        step();
        start   = 1'b0;
        check("launch_busy",  128'(busy),      128'(1));
        check("launch_count", 128'(count),     128'(0));
        check("launch_valid", 128'(sum_valid), 128'(0));
    endtask

    task automatic feed(input int from, input int gap_max, input int hold_cycles, input bit handshake);
        for (int i = from; i < pq.size(); i++) begin
            repeat ($urandom_range(gap_max, 0)) step();
            prod_valid = 1'b1;
            prod_in    = pq[i];
            step();
            prod_valid = 1'b0;
            if (i < pq.size() - 1) begin
                check("acc_busy",  128'(busy),      128'(1));
                check("acc_count", 128'(count),     128'(i + 1));
                check("acc_valid", 128'(sum_valid), 128'(0));
            end
        end
        model(AW,  exp_sum_w, exp_ovf_w);
        model(AWN, exp_sum_n, exp_ovf_n);
        check("done_valid",    128'(sum_valid),  128'(1));
        check("done_sum",      128'(sum_out),    exp_sum_w);
        check("done_overflow", 128'(overflow),   128'(exp_ovf_w));
        check("done_busy",     128'(busy),       128'(0));
        check("done_count",    128'(count),      128'(pq.size()));
        check("done_drop_err", 128'(drop_err),   128'(exp_drop));
        check("n_done_sum",    128'(sum_out_n),  exp_sum_n);
        check("n_done_ovf",    128'(overflow_n), 128'(exp_ovf_n));
        repeat (hold_cycles) begin
            step();
            check("hold_valid", 128'(sum_valid), 128'(1));
            check("hold_sum",   128'(sum_out),   exp_sum_w);
        end
        if (handshake) begin
            sum_ready = 1'b1;
            step();
            sum_ready = 1'b0;
            check("hs_valid",    128'(sum_valid), 128'(0));
            check("hs_sum_kept", 128'(sum_out),   exp_sum_w);
            check("hs_count",    128'(count),     128'(pq.size()));
        end
    endtask

    initial begin
        reset = 1'b0; en = 1'b1; start = 1'b0; vec_len = '0;
        prod_in = '0; prod_valid = 1'b0; sum_ready = 1'b0; exp_drop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        reset = 1'b1;
        step();

        // Basic dot product 6 - 4 + 10
        pq = '{64'd6, 64'hFFFF_FFFF_FFFF_FFFC, 64'd10};
        launch(3);
        feed(0, 1, 0, 1);
        check("t1_sum_12", 128'(sum_out), 128'd12);

        // Two full-scale positives: fits in 72 bits, wraps to -2 in 64 bits
        pq = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF};
        launch(2);
        feed(0, 0, 0, 1);
        check("t2_sum72", 128'(sum_out),    128'h0_FFFF_FFFF_FFFF_FFFE);
        check("t2_ovf72", 128'(overflow),   128'(0));
        check("t2_sum64", 128'(sum_out_n),  128'hFFFF_FFFF_FFFF_FFFE);
        check("t2_ovf64", 128'(overflow_n), 128'(1));

        // Zero-length run produces an immediate zero result
        start = 1'b1; vec_len = '0;
        step();
        start = 1'b0;
        check("t3_valid", 128'(sum_valid),  128'(1));
        check("t3_sum",   128'(sum_out),    128'(0));
        check("t3_busy",  128'(busy),       128'(0));
        check("t3_count", 128'(count),      128'(0));
        check("t3_ovf64", 128'(overflow_n), 128'(0));
        sum_ready = 1'b1;
        step();
        sum_ready = 1'b0;
        check("t3_hs_valid", 128'(sum_valid), 128'(0));

        // Stall the result for 5 cycles, then re-arm in the handshake cycle
        pq.delete();
        repeat (3) pq.push_back({$urandom, $urandom});
        launch(3);
        feed(0, 1, 5, 0);
        pq = '{64'hFFFF_FFFF_FFFF_FFF9};
        sum_ready = 1'b1; start = 1'b1; vec_len = 8'd1;
        step();
        sum_ready = 1'b0; start = 1'b0;
        check("t4_rearm_valid", 128'(sum_valid), 128'(0));
        check("t4_rearm_busy",  128'(busy),      128'(1));
        check("t4_rearm_count", 128'(count),     128'(0));
        feed(0, 0, 0, 1);
        check("t4_sum_m7", 128'(sum_out), 128'hFF_FFFF_FFFF_FFFF_FFF9);

        // Stray product in IDLE, then a run with a 3-cycle clock-enable freeze
        prod_valid = 1'b1; prod_in = 64'd55;
        step();
        prod_valid = 1'b0;
        exp_drop = 1'b1;
        check("t5_drop", 128'(drop_err), 128'(1));
        pq = '{64'd5, 64'd6, 64'd7};
        launch(3);
        prod_valid = 1'b1; prod_in = pq[0];
        step();
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            prod_valid = (k != 1);
            prod_in    = 64'd100;
            step();
            check("t5_frozen_count", 128'(count), 128'(1));
            check("t5_frozen_busy",  128'(busy),  128'(1));
        end
        en = 1'b1; prod_valid = 1'b0;
        feed(1, 1, 2, 1);
        check("t5_sum_18", 128'(sum_out), 128'd18);

        // Asynchronous reset in the middle of a run, then a clean run of 4
        pq.delete();
        repeat (4) pq.push_back(64'($urandom_range(2000, 0)) - 64'd1000);
        launch(4);
        for (int i = 0; i < 2; i++) begin
            prod_valid = 1'b1; prod_in = pq[i];
            step();
        end
        prod_valid = 1'b0;
        check("t6_count_2", 128'(count), 128'(2));
        #2 reset = 1'b0;
        #1;
        check_reset_state();
        exp_drop = 1'b0;
        #2 reset = 1'b1;
        step();
        pq.delete();
        repeat (4) pq.push_back({$urandom, $urandom});
        launch(4);
        feed(0, 2, 1, 1);

        // Randomized runs mixing full-scale and small products
        for (int r = 0; r < 25; r++) begin
            int len;
            len = $urandom_range(12, 1);
            pq.delete();
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(1, 0) == 1) pq.push_back({$urandom, $urandom});
                else pq.push_back(64'($urandom_range(2000, 0)) - 64'd1000);
            end
            launch(len);
            feed(0, 2, $urandom_range(3, 0), 1);
        end

        // Longest run of most-negative products: exact in 72 bits, overflows 64 bits
        pq.delete();
        repeat (255) pq.push_back(64'h8000_0000_0000_0000);
        launch(255);
        feed(0, 0, 0, 1);
        check("t8_ovf72", 128'(overflow),   128'(0));
        check("t8_ovf64", 128'(overflow_n), 128'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
